square_motion_controller: RTL and testbench

Per-frame motion scheduler for the 720p square test pattern. It sits between the video signal generator and the pixel paint logic. On each new-frame pulse it advances the square's top-left position with edge bounce and cycles a colour index on every bounce. It commits new values only in vertical blanking, so the paint logic sees stable coordinates for a whole active frame.

---
 rtl/square_motion_controller.sv | 203 ++++++++++++++++++++
 tb/tb_square_motion_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/square_motion_controller.sv
// square_motion_controller
// Moves the square's top-left corner once per frame and bounces it off the
// screen edges. The colour index advances once for each frame that has a
// bounce. New coordinates are committed only after a new-frame pulse, so the
// paint logic sees the same values for the whole active frame.
module square_motion_controller #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int SQ_SIZE  = 200,
  parameter int X_START  = 220,
  parameter int Y_START  = 140,
  parameter int SPEED    = 4,
  parameter int X_W      = $clog2(H_ACTIVE),
  parameter int Y_W      = $clog2(V_ACTIVE)
) (
  input  logic           i_clk_pxl,
  input  logic           i_reset,
  input  logic           i_nf,
  input  logic           i_pause_toggle,
  output logic [X_W-1:0] o_sq_x,
  output logic [Y_W-1:0] o_sq_y,
  output logic [1:0]     o_colour_idx,
  output logic           o_update,
  output logic           o_running
);

  // Largest legal top-left positions, widened by one bit so that the
  // "position + step" sum can be compared without wrapping.
  localparam int X_MAX_I = H_ACTIVE - SQ_SIZE;
  localparam int Y_MAX_I = V_ACTIVE - SQ_SIZE;

  localparam logic [X_W:0]   X_MAX   = X_MAX_I[X_W:0];
  localparam logic [Y_W:0]   Y_MAX   = Y_MAX_I[Y_W:0];
  localparam logic [X_W:0]   X_STEP  = SPEED[X_W:0];
  localparam logic [Y_W:0]   Y_STEP  = SPEED[Y_W:0];
  localparam logic [X_W-1:0] X_RST   = X_START[X_W-1:0];
  localparam logic [Y_W-1:0] Y_RST   = Y_START[Y_W-1:0];

  typedef enum logic [2:0] {
    S_PAUSE,
    S_WAIT_FRAME,
    S_MOVE_X,
    S_MOVE_Y,
    S_COMMIT
  } state_t;

  state_t         state_q,   state_d;
  logic [X_W-1:0] x_q,       x_d;       // working x, private to this block
  logic [Y_W-1:0] y_q,       y_d;       // working y, private to this block
  logic           dx_q,      dx_d;      // 0: moving right, 1: moving left
  logic           dy_q,      dy_d;      // 0: moving down,  1: moving up
  logic           bx_q,      bx_d;      // x bounced during this frame
  logic           by_q,      by_d;      // y bounced during this frame
  logic           pend_q,    pend_d;    // pause requested mid-update
  logic [X_W-1:0] sq_x_q,    sq_x_d;
  logic [Y_W-1:0] sq_y_q,    sq_y_d;
  logic [1:0]     colour_q,  colour_d;
  logic           update_q,  update_d;
  logic           running_q, running_d;

  logic [X_W:0]   nx;
  logic [Y_W:0]   ny;

  // Next-state and next-value logic for the whole scheduler.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    bx_d      = bx_q;
    by_d      = by_q;
    pend_d    = pend_q;
    sq_x_d    = sq_x_q;
    sq_y_d    = sq_y_q;
    colour_d  = colour_q;
    update_d  = 1'b0;
    nx        = {1'b0, x_q} + X_STEP;
    ny        = {1'b0, y_q} + Y_STEP;

    case (state_q)
      S_WAIT_FRAME: begin
        // A frame pulse wins over a simultaneous toggle; the toggle is
        // remembered and honoured once the update has been committed.
        if (i_nf) begin
          state_d = S_MOVE_X;
          if (i_pause_toggle) pend_d = 1'b1;
        end else if (i_pause_toggle) begin
          state_d = S_PAUSE;
        end
      end

      S_MOVE_X: begin
        if (i_pause_toggle) pend_d = 1'b1;
        if (!dx_q) begin
          if (nx >= X_MAX) begin
            x_d  = X_MAX[X_W-1:0];
            dx_d = 1'b1;
            bx_d = 1'b1;
          end else begin
            x_d = nx[X_W-1:0];
          end
        end else begin
          if ({1'b0, x_q} <= X_STEP) begin
            x_d  = '0;
            dx_d = 1'b0;
            bx_d = 1'b1;
          end else begin
            x_d = x_q - X_STEP[X_W-1:0];
          end
        end
        state_d = S_MOVE_Y;
      end

      S_MOVE_Y: begin
        if (i_pause_toggle) pend_d = 1'b1;
        if (!dy_q) begin
          if (ny >= Y_MAX) begin
            y_d  = Y_MAX[Y_W-1:0];
            dy_d = 1'b1;
            by_d = 1'b1;
          end else begin
            y_d = ny[Y_W-1:0];
          end
        end else begin
          if ({1'b0, y_q} <= Y_STEP) begin
            y_d  = '0;
            dy_d = 1'b0;
            by_d = 1'b1;
          end else begin
            y_d = y_q - Y_STEP[Y_W-1:0];
          end
        end
        state_d = S_COMMIT;
      end

      S_COMMIT: begin
        sq_x_d   = x_q;
        sq_y_d   = y_q;
        update_d = 1'b1;
        // A corner hit sets both flags but still advances the colour once.
        if (bx_q || by_q) colour_d = colour_q + 2'd1;
        bx_d = 1'b0;
        by_d = 1'b0;
        // A toggle arriving on this very cycle is folded in so it is not lost.
        if (pend_q || i_pause_toggle) begin
          state_d = S_PAUSE;
          pend_d  = 1'b0;
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end

      S_PAUSE: begin
        if (i_pause_toggle) state_d = S_WAIT_FRAME;
      end

      default: state_d = S_WAIT_FRAME;
    endcase

    running_d = (state_d != S_PAUSE);
  end

  // State and output registers; reset restores the power-up position at once.
  always_ff @(posedge i_clk_pxl or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_WAIT_FRAME;
      x_q       <= X_RST;
      y_q       <= Y_RST;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      bx_q      <= 1'b0;
      by_q      <= 1'b0;
      pend_q    <= 1'b0;
      sq_x_q    <= X_RST;
      sq_y_q    <= Y_RST;
      colour_q  <= 2'd0;
      update_q  <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      pend_q    <= pend_d;
      sq_x_q    <= sq_x_d;
      sq_y_q    <= sq_y_d;
      colour_q  <= colour_d;
      update_q  <= update_d;
      running_q <= running_d;
    end
  end

  assign o_sq_x       = sq_x_q;
  assign o_sq_y       = sq_y_q;
  assign o_colour_idx = colour_q;
  assign o_update     = update_q;
  assign o_running    = running_q;

endmodule

// File: tb/tb_square_motion_controller.sv
// Directed bench for square_motion_controller: expected commits are pushed
// to a queue when a frame pulse is driven and popped when o_update fires.
module tb_square_motion_controller;

  localparam int XMAX = 1080;
  localparam int YMAX = 520;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_nf;
  logic        i_pause_toggle;
  logic [10:0] o_sq_x;
  logic [9:0]  o_sq_y;
  logic [1:0]  o_colour_idx;
  logic        o_update;
  logic        o_running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int col;
  } exp_t;

  exp_t sb[$];

  // Reference model of the square's motion.
  int mx, my, mdx, mdy, mcol;

  square_motion_controller dut (
    .i_clk_pxl      (clk),
    .i_reset        (i_reset),
    .i_nf           (i_nf),
    .i_pause_toggle (i_pause_toggle),
    .o_sq_x         (o_sq_x),
    .o_sq_y         (o_sq_y),
    .o_colour_idx   (o_colour_idx),
    .o_update       (o_update),
    .o_running      (o_running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 220; my = 140; mdx = 1; mdy = 1; mcol = 0;
    sb.delete();
  endtask

  // Advance the model by one frame and queue the commit it predicts.
  task automatic model_frame();
    int  t;
    bit  b;
    exp_t e;
    b = 1'b0;
    t = mx + STEP * mdx;
    if (t >= XMAX)   begin mx = XMAX; mdx = -1; b = 1'b1; end
    else if (t <= 0) begin mx = 0;    mdx = 1;  b = 1'b1; end
    else mx = t;
    t = my + STEP * mdy;
    if (t >= YMAX)   begin my = YMAX; mdy = -1; b = 1'b1; end
    else if (t <= 0) begin my = 0;    mdy = 1;  b = 1'b1; end
    else my = t;
    if (b) mcol = (mcol + 1) % 4;
    e.x = mx; e.y = my; e.col = mcol;
    sb.push_back(e);
  endtask

  // Pulse i_nf for one clock; returns #1 after the edge that sampled it.
  task automatic drive_nf();
    @(negedge clk);
    i_nf = 1'b1;
    @(posedge clk);
    #1 i_nf = 1'b0;
  endtask

  // Wait up to 6 edges for o_update; lat = edges waited, 0 on timeout.
  task automatic await_update(output int lat);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (o_update === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic compare_commit(input string tag, input int lat, input int want_lat);
    exp_t e;
    check({tag, "_latency"}, lat, want_lat);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      if (lat != 0) begin
        check({tag, "_x"}, o_sq_x, e.x);
        check({tag, "_y"}, o_sq_y, e.y);
        check({tag, "_col"}, o_colour_idx, e.col);
        $display("commit %s x=%0d y=%0d col=%0d", tag, o_sq_x, o_sq_y, o_colour_idx);
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int lat;
    model_frame();
    drive_nf();
    await_update(lat);
    compare_commit(tag, lat, 3);
    @(posedge clk);
    #1 check({tag, "_upd_pulse"}, o_update, 1'b0);
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int lat;
    int seen;
    int hold_x, hold_y, hold_c;
    i_reset = 1'b0;
    i_nf = 1'b0;
    i_pause_toggle = 1'b0;

    // Reset with no frame pulses: power-up position, no update.
    apply_reset();
    #1;
    check("rst_x", o_sq_x, 220);
    check("rst_y", o_sq_y, 140);
    check("rst_col", o_colour_idx, 0);
    check("rst_running", o_running, 1);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (o_update === 1'b1) seen++;
    end
    check("rst_no_update", seen, 0);

    // First frame: three-edge latency, one-cycle pulse.
    run_frame("f1");
    check("f1_x_abs", o_sq_x, 224);
    check("f1_y_abs", o_sq_y, 144);

    // Run up to the bottom bounce.
    for (int f = 2; f <= 95; f++) run_frame("run");
    check("f95_y", o_sq_y, 520);
    check("f95_col", o_colour_idx, 1);
    run_frame("f96");
    check("f96_y", o_sq_y, 516);
    check("f96_x", o_sq_x, 604);

    // Right-edge bounce.
    for (int f = 97; f <= 215; f++) run_frame("run");
    check("f215_x", o_sq_x, 1080);
    check("f215_col", o_colour_idx, 2);
    run_frame("f216");
    check("f216_x", o_sq_x, 1076);

    // Left edge coincides with a top-edge hit: one colour step only.
    for (int f = 217; f <= 484; f++) run_frame("run");
    check("f484_x", o_sq_x, 4);
    check("f484_col", o_colour_idx, 0);
    run_frame("f485");
    check("f485_x", o_sq_x, 0);
    check("f485_y", o_sq_y, 0);
    check("f485_col", o_colour_idx, 1);
    run_frame("f486");
    check("f486_x", o_sq_x, 4);

    // Pause toggle while in S_MOVE_Y: update completes, then pause.
    model_frame();
    drive_nf();                 // edge E sampled i_nf
    @(posedge clk);             // E+1: MOVE_X done
    #1 i_pause_toggle = 1'b1;
    @(posedge clk);             // E+2: toggle sampled in MOVE_Y
    #1 i_pause_toggle = 1'b0;
    check("pause_running_mid", o_running, 1);
    await_update(lat);
    compare_commit("pause_commit", lat, 1);
    check("pause_running", o_running, 0);
    hold_x = o_sq_x; hold_y = o_sq_y; hold_c = o_colour_idx;
    for (int p = 0; p < 10; p++) begin
      drive_nf();
      seen = 0;
      repeat (5) begin
        @(posedge clk);
        #1 if (o_update === 1'b1) seen++;
      end
      check("paused_no_update", seen, 0);
      check("paused_x", o_sq_x, hold_x);
      check("paused_y", o_sq_y, hold_y);
      check("paused_running", o_running, 0);
    end
    check("paused_col", o_colour_idx, hold_c);
    @(negedge clk);
    i_pause_toggle = 1'b1;
    @(posedge clk);
    #1 i_pause_toggle = 1'b0;
    check("resume_running", o_running, 1);
    run_frame("resume");
    check("resume_dx", o_sq_x - hold_x, 4);

    // Asynchronous reset in S_MOVE_X after 50 frames.
    apply_reset();
    for (int f = 1; f <= 50; f++) run_frame("pre_rst");
    check("pre_rst_x", o_sq_x, 420);
    drive_nf();                 // now in S_MOVE_X
    #2 i_reset = 1'b1;
    #1;
    check("arst_x", o_sq_x, 220);
    check("arst_y", o_sq_y, 140);
    check("arst_col", o_colour_idx, 0);
    check("arst_upd", o_update, 0);
    check("arst_running", o_running, 1);
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (o_update === 1'b1) seen++;
    end
    check("arst_no_update", seen, 0);
    run_frame("post_rst");
    check("post_rst_x", o_sq_x, 224);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
